div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 40, max cycles from div_start to div_complete before a timeout fault.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous reset, asserted when 0.
REQ-005 req_valid  input  1  execution unit presents a divide request.
REQ-006 req_ready  output  1  sequencer accepts request this cycle.
REQ-007 req_op  input  2  0=DIV, 1=IDIV, 2=AAM, 3=reserved.
REQ-008 req_is_8_bit  input  1  byte form; ignored for AAM, which is always byte.
REQ-009 req_ax, req_dx, req_src  input  16 each  AX, DX, divisor source; the AAM immediate is in req_src[7:0].
REQ-010 div_start, div_is_8_bit, div_is_signed  output  1 each  divider controls.
REQ-011 div_dividend  output  32; div_divisor  output  16  divider operands.
REQ-012 div_complete, div_error  input  1 each; div_quotient, div_remainder  input  16 each  divider results.
REQ-013 wb_valid  output  1; wb_ready  input  1  writeback handshake.
REQ-014 wb_ax  output  16; wb_dx  output  16; wb_dx_en  output  1  writeback data and DX enable.
REQ-015 fault  output  1; fault_timeout  output  1  divide-error (INT 0) indication and its cause flag.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, RESULT, FAULT.
REQ-017 req_ready SHALL be 1 only in IDLE; a transfer is req_valid & req_ready.
REQ-018 On transfer, operands SHALL be registered and state SHALL move to ISSUE.
REQ-019 req_op=3 SHALL go directly to FAULT with fault_timeout=0.
REQ-020 Operand formatting:
- 16-bit DIV/IDIV: dividend={req_dx,req_ax}, divisor=req_src.
- 8-bit DIV/IDIV: dividend={16'h0,req_ax}, divisor={8'h0,req_src[7:0]}.
- AAM: dividend={24'h0,req_ax[7:0]}, divisor={8'h0,req_src[7:0]}, unsigned, byte.
REQ-021 div_is_signed SHALL be 1 only for IDIV.
REQ-022 div_dividend, div_divisor, div_is_8_bit, div_is_signed SHALL be driven from registers.
REQ-023 Those registered operands SHALL stay stable from ISSUE until leaving WAIT.
REQ-024 div_start SHALL pulse high for exactly the one ISSUE cycle; ISSUE SHALL always move to WAIT.
REQ-025 In WAIT, a cycle counter SHALL count from 1 and leave WAIT on the first of:
- div_complete=1 with div_error=0 -> RESULT.
- div_complete=1 with div_error=1 -> FAULT, fault_timeout=0.
- counter reaching TIMEOUT_CYCLES with no div_complete -> FAULT, fault_timeout=1.
REQ-026 If div_complete and the timeout occur in the same cycle, div_complete SHALL win.
REQ-027 On leaving WAIT for RESULT, writeback SHALL be captured into registers:
- 16-bit: wb_ax=quotient, wb_dx=remainder, wb_dx_en=1.
- 8-bit: wb_ax={remainder[7:0],quotient[7:0]}, wb_dx_en=0.
- AAM: wb_ax={quotient[7:0],remainder[7:0]}, wb_dx_en=0.
REQ-028 wb_valid SHALL be 1 in RESULT, with wb_ax, wb_dx, wb_dx_en held stable until wb_ready=1.
REQ-029 RESULT SHALL go to IDLE on the wb_valid & wb_ready cycle.
REQ-030 fault SHALL be 1 in FAULT, with fault_timeout held stable; FAULT SHALL go to IDLE on the wb_ready=1 cycle.
REQ-031 wb_valid SHALL be 0 in FAULT, and no writeback SHALL occur on a fault.
REQ-032 The earliest next request acceptance SHALL be the cycle after the RESULT/FAULT handshake; latency from acceptance to wb_valid = 2 + divider cycles.
REQ-033 In IDLE and ISSUE, div_complete SHALL be ignored.

Reset
REQ-034 While reset=0: state=IDLE, div_start=0, wb_valid=0, fault=0, fault_timeout=0.
REQ-035 While reset=0: wb_ax=0, wb_dx=0, wb_dx_en=0, counter=0, operand registers=0.
REQ-036 req_ready SHALL be 0 while reset=0 and 1 from the first edge after release.
REQ-037 Reset in any state, including mid-WAIT, SHALL discard the operation with no writeback and no fault.

Verification
REQ-038 DIV16, DX=0x0001, AX=0x0000, src=0x0002 -> wb_ax=0x8000, wb_dx=0x0000, wb_dx_en=1.
REQ-039 IDIV8, AX=0xFFF9, src=0x0002 -> wb_ax=0xFFFD (AH=-1, AL=-3), wb_dx_en=0.
REQ-040 AAM, AL=0x3F, imm=0x0A -> wb_ax=0x0603; AAM with imm=0x00 -> fault=1, fault_timeout=0, wb_valid never 1.
REQ-041 DIV8, AX=0x0400, src=0x02 (overflow) -> fault=1; wb_ready low 5 cycles -> fault held; req_ready=0 throughout.
REQ-042 Divider model never completes -> fault_timeout=1 exactly TIMEOUT_CYCLES cycles after div_start.
REQ-043 Reset pulse mid-WAIT -> IDLE with no wb_valid/fault; next DIV16 0x0000_0064/0x000A -> wb_ax=0x000A, wb_dx=0.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: control sequencer between an x86-style execution unit and an
// iterative divider. It accepts a DIV/IDIV/AAM request and formats the divider
// operands. It then launches the divider and waits for it, with a timeout. On
// success it formats the AX/DX writeback. On a divide error, a reserved op or
// a timeout it raises a divide-error fault instead.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_op, req_is_8_bit       0=DIV 1=IDIV 2=AAM 3=reserved; byte form
//   req_ax, req_dx, req_src    AX, DX, divisor source (AAM immediate in [7:0])
//   div_start                  one-cycle launch pulse to the divider
//   div_is_8_bit/div_is_signed divider mode, registered
//   div_dividend, div_divisor  divider operands, registered
//   div_complete, div_error    divider done / divide overflow or zero divisor
//   div_quotient/remainder     divider results
//   wb_valid/wb_ready          writeback handshake (wb_ready also acks a fault)
//   wb_ax, wb_dx, wb_dx_en     writeback data and DX write enable
//   fault, fault_timeout       divide-error indication and timeout cause
module div_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_is_8_bit,
  input  logic [15:0] req_ax,
  input  logic [15:0] req_dx,
  input  logic [15:0] req_src,
  output logic        div_start,
  output logic        div_is_8_bit,
  output logic        div_is_signed,
  output logic [31:0] div_dividend,
  output logic [15:0] div_divisor,
  input  logic        div_complete,
  input  logic        div_error,
  input  logic [15:0] div_quotient,
  input  logic [15:0] div_remainder,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [15:0] wb_ax,
  output logic [15:0] wb_dx,
  output logic        wb_dx_en,
  output logic        fault,
  output logic        fault_timeout
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DVD_W  = 32;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] OP_IDIV = 2'd1;
  localparam logic [1:0] OP_AAM  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESULT,
    ST_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                div_start_q, div_start_d;
  logic                div_is_8_bit_q, div_is_8_bit_d;
  logic                div_is_signed_q, div_is_signed_d;
  logic                is_aam_q, is_aam_d;
  logic [DVD_W-1:0]    div_dividend_q, div_dividend_d;
  logic [WORD_W-1:0]   div_divisor_q, div_divisor_d;
  logic                wb_valid_q, wb_valid_d;
  logic [WORD_W-1:0]   wb_ax_q, wb_ax_d;
  logic [WORD_W-1:0]   wb_dx_q, wb_dx_d;
  logic                wb_dx_en_q, wb_dx_en_d;
  logic                fault_q, fault_d;
  logic                fault_timeout_q, fault_timeout_d;

  logic [DVD_W-1:0]    fmt_dividend;
  logic [WORD_W-1:0]   fmt_divisor;
  logic                fmt_is_8_bit;
  logic                fmt_is_signed;
  logic                xfer;

  assign xfer = req_valid & req_ready_q;

  // Divider operand formatting from the raw request fields.
  always_comb begin
    fmt_dividend  = {req_dx, req_ax};
    fmt_divisor   = req_src;
    fmt_is_8_bit  = req_is_8_bit;
    fmt_is_signed = (req_op == OP_IDIV);
    if (req_op == OP_AAM) begin
      // AAM is always an unsigned byte divide of AL by the immediate.
      fmt_dividend  = {24'h0, req_ax[7:0]};
      fmt_divisor   = {8'h0, req_src[7:0]};
      fmt_is_8_bit  = 1'b1;
      fmt_is_signed = 1'b0;
    end else if (req_is_8_bit) begin
      fmt_dividend = {16'h0, req_ax};
      fmt_divisor  = {8'h0, req_src[7:0]};
    end
  end

  // Next-state, operand capture, timeout counter and writeback capture.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    div_is_8_bit_d  = div_is_8_bit_q;
    div_is_signed_d = div_is_signed_q;
    is_aam_d        = is_aam_q;
    div_dividend_d  = div_dividend_q;
    div_divisor_d   = div_divisor_q;
    wb_ax_d         = wb_ax_q;
    wb_dx_d         = wb_dx_q;
    wb_dx_en_d      = wb_dx_en_q;
    fault_timeout_d = fault_timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          div_dividend_d  = fmt_dividend;
          div_divisor_d   = fmt_divisor;
          div_is_8_bit_d  = fmt_is_8_bit;
          div_is_signed_d = fmt_is_signed;
          is_aam_d        = (req_op == OP_AAM);
          if (req_op == OP_RSVD) begin
            state_d         = ST_FAULT;
            fault_timeout_d = 1'b0;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(1);
      end
      ST_WAIT: begin
        // Completion is checked first so it beats a coincident timeout.
        if (div_complete) begin
          cnt_d = '0;
          if (div_error) begin
            state_d         = ST_FAULT;
            fault_timeout_d = 1'b0;
          end else begin
            state_d = ST_RESULT;
            if (is_aam_q) begin
              wb_ax_d    = {div_quotient[7:0], div_remainder[7:0]};
              wb_dx_d    = '0;
              wb_dx_en_d = 1'b0;
            end else if (div_is_8_bit_q) begin
              wb_ax_d    = {div_remainder[7:0], div_quotient[7:0]};
              wb_dx_d    = '0;
              wb_dx_en_d = 1'b0;
            end else begin
              wb_ax_d    = div_quotient;
              wb_dx_d    = div_remainder;
              wb_dx_en_d = 1'b1;
            end
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          cnt_d           = '0;
          state_d         = ST_FAULT;
          fault_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESULT: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (wb_ready) begin
          state_d         = ST_IDLE;
          fault_timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the next state so they register with it.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    div_start_d = (state_d == ST_ISSUE);
    wb_valid_d  = (state_d == ST_RESULT);
    fault_d     = (state_d == ST_FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      req_ready_q     <= 1'b0;
      div_start_q     <= 1'b0;
      div_is_8_bit_q  <= 1'b0;
      div_is_signed_q <= 1'b0;
      is_aam_q        <= 1'b0;
      div_dividend_q  <= '0;
      div_divisor_q   <= '0;
      wb_valid_q      <= 1'b0;
      wb_ax_q         <= '0;
      wb_dx_q         <= '0;
      wb_dx_en_q      <= 1'b0;
      fault_q         <= 1'b0;
      fault_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      req_ready_q     <= req_ready_d;
      div_start_q     <= div_start_d;
      div_is_8_bit_q  <= div_is_8_bit_d;
      div_is_signed_q <= div_is_signed_d;
      is_aam_q        <= is_aam_d;
      div_dividend_q  <= div_dividend_d;
      div_divisor_q   <= div_divisor_d;
      wb_valid_q      <= wb_valid_d;
      wb_ax_q         <= wb_ax_d;
      wb_dx_q         <= wb_dx_d;
      wb_dx_en_q      <= wb_dx_en_d;
      fault_q         <= fault_d;
      fault_timeout_q <= fault_timeout_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign div_start     = div_start_q;
  assign div_is_8_bit  = div_is_8_bit_q;
  assign div_is_signed = div_is_signed_q;
  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign wb_valid      = wb_valid_q;
  assign wb_ax         = wb_ax_q;
  assign wb_dx         = wb_dx_q;
  assign wb_dx_en      = wb_dx_en_q;
  assign fault         = fault_q;
  assign fault_timeout = fault_timeout_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: self-checking bench for div_sequencer. The bench plays
// the execution unit, the divider and the writeback stage. Expected outcomes
// come from a reference x86 divide model and are queued when each request is
// driven, then popped when the sequencer reports a writeback or a fault.
module tb_div_sequencer;

  localparam int unsigned TIMEOUT = 40;
  localparam int LIMIT = TIMEOUT + 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic        req_is_8_bit = 1'b0;
  logic [15:0] req_ax = '0, req_dx = '0, req_src = '0;
  logic        div_start, div_is_8_bit, div_is_signed;
  logic [31:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_complete = 1'b0, div_error = 1'b0;
  logic [15:0] div_quotient = '0, div_remainder = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [15:0] wb_ax, wb_dx;
  logic        wb_dx_en, fault, fault_timeout;

  always #5 clk = ~clk;

  div_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_is_8_bit(req_is_8_bit), .req_ax(req_ax), .req_dx(req_dx), .req_src(req_src),
    .div_start(div_start), .div_is_8_bit(div_is_8_bit), .div_is_signed(div_is_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_complete(div_complete), .div_error(div_error),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_ax(wb_ax), .wb_dx(wb_dx), .wb_dx_en(wb_dx_en),
    .fault(fault), .fault_timeout(fault_timeout)
  );

  typedef struct packed {
    logic        valid;
    logic        is_fault;
    logic        timeout;
    logic [15:0] ax;
    logic [15:0] dx;
    logic        dx_en;
  } wb_t;

  typedef struct {
    bit          got;
    wb_t         res;
    int          start_cnt;
    int          start_at;
    int          lat;
    bit          stable;
    bit          held;
    bit          ready_after;
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic        is8;
    logic        sgn;
  } obs_t;

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Comparable view of an outcome: data fields only matter on a real writeback.
  function automatic logic [35:0] key(input wb_t w);
    logic [35:0] k;
    k = {w.valid, w.is_fault, w.timeout, 33'h0};
    if (!w.is_fault) begin
      k[32:17] = w.ax;
      k[16:1]  = w.dx_en ? w.dx : 16'h0;
      k[0]     = w.dx_en;
    end
    return k;
  endfunction

  // Reference x86 divide: divider response plus expected writeback.
  task automatic model(input logic [1:0] op, input logic is8,
                       input logic [15:0] ax, input logic [15:0] dx, input logic [15:0] src,
                       output logic err, output logic [15:0] q, output logic [15:0] r,
                       output wb_t e);
    longint n, d, sq, sr;
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    logic signed [15:0] d16;
    logic signed [31:0] s32;
    err = 1'b0; q = '0; r = '0; e = '0; sq = 0; sr = 0;
    case (op)
      2'd0: begin
        n = is8 ? longint'(ax) : longint'({dx, ax});
        d = is8 ? longint'(src[7:0]) : longint'(src);
        if (d == 0) err = 1'b1;
        else begin
          sq = n / d; sr = n % d;
          err = is8 ? (sq > 255) : (sq > 65535);
        end
      end
      2'd1: begin
        s16 = ax; s32 = {dx, ax}; s8 = src[7:0]; d16 = src;
        n = is8 ? longint'(s16) : longint'(s32);
        d = is8 ? longint'(s8) : longint'(d16);
        if (d == 0) err = 1'b1;
        else begin
          sq = n / d; sr = n % d;
          err = is8 ? (sq < -128 || sq > 127) : (sq < -32768 || sq > 32767);
        end
      end
      2'd2: begin
        n = longint'(ax[7:0]); d = longint'(src[7:0]);
        if (d == 0) err = 1'b1;
        else begin sq = n / d; sr = n % d; end
      end
      default: err = 1'b1;
    endcase
    if (!err) begin q = 16'(sq); r = 16'(sr); end
    e.valid = !err;
    e.is_fault = err;
    if (!err) begin
      if (op == 2'd2) e.ax = {q[7:0], r[7:0]};
      else if (is8) e.ax = {r[7:0], q[7:0]};
      else begin e.ax = q; e.dx = r; e.dx_en = 1'b1; end
    end
  endtask

  // Drives one request, plays the divider (complete after lat WAIT cycles),
  // records what the sequencer did, then acknowledges after hold cycles.
  task automatic run_txn(input logic [1:0] op, input logic is8,
                         input logic [15:0] ax, input logic [15:0] dx, input logic [15:0] src,
                         input int lat, input bit respond, input bit expect_timeout,
                         input int hold, output obs_t o);
    logic err;
    logic [15:0] q, r;
    wb_t e;
    int cyc;
    model(op, is8, ax, dx, src, err, q, r, e);
    if (expect_timeout) begin
      e = '0; e.is_fault = 1'b1; e.timeout = 1'b1;
    end
    exp_q.push_back(e);
    o.got = 0; o.res = '0; o.start_cnt = 0; o.start_at = -1; o.lat = 0;
    o.stable = 1; o.held = 1; o.ready_after = 0;
    o.dvd = '0; o.dvs = '0; o.is8 = 1'b0; o.sgn = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && cyc < LIMIT) begin @(negedge clk); cyc++; end
    req_op = op; req_is_8_bit = is8; req_ax = ax; req_dx = dx; req_src = src;
    req_valid = 1'b1;
    cyc = 0;
    while (!o.got && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; div_complete = 1'b0; div_error = 1'b0;
      if (div_start === 1'b1) begin
        o.start_cnt++;
        if (o.start_at < 0) begin
          o.start_at = cyc;
          o.dvd = div_dividend; o.dvs = div_divisor; o.is8 = div_is_8_bit; o.sgn = div_is_signed;
        end
      end else if (o.start_at >= 0 &&
                   {div_dividend, div_divisor, div_is_8_bit, div_is_signed} !== {o.dvd, o.dvs, o.is8, o.sgn}) begin
        o.stable = 0;
      end
      if (respond && o.start_at >= 0 && cyc == o.start_at + lat) begin
        div_complete = 1'b1; div_error = err; div_quotient = q; div_remainder = r;
      end
      if (wb_valid === 1'b1 || fault === 1'b1) begin
        o.got = 1; o.lat = cyc;
        o.res = {wb_valid, fault, fault_timeout, wb_ax, wb_dx, wb_dx_en};
      end
    end
    if (o.got) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if ({wb_valid, fault, fault_timeout, wb_ax, wb_dx, wb_dx_en} !== o.res || req_ready !== 1'b0)
          o.held = 0;
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      o.ready_after = (req_ready === 1'b1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req_ready, div_start, wb_valid, fault, fault_timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {req_ready, div_start, wb_valid, fault, fault_timeout});
    end
    n_tests++;
    if ({wb_ax, wb_dx, wb_dx_en} !== 33'h0) begin
      n_fail++; $display("FAIL reset_wb: got %h expected 0", {wb_ax, wb_dx, wb_dx_en});
    end
    n_tests++;
    if ({div_dividend, div_divisor, div_is_8_bit, div_is_signed} !== 50'h0) begin
      n_fail++; $display("FAIL reset_operands: got %h expected 0", {div_dividend, div_divisor, div_is_8_bit, div_is_signed});
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: got %b expected 0", req_ready);
    end
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_release: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_div16();
    obs_t o;
    wb_t e;
    run_txn(2'd0, 1'b0, 16'h0000, 16'h0001, 16'h0002, 3, 1, 0, 0, o);
    e = exp_q.pop_front();
    n_tests++;
    if (!o.got || key(o.res) !== key(e)) begin
      n_fail++; $display("FAIL div16_result: got %h expected %h (seen=%0d)", key(o.res), key(e), o.got);
    end
    n_tests++;
    if ({o.dvd, o.dvs, o.is8, o.sgn} !== {32'h0001_0000, 16'h0002, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL div16_operands: got %h/%h/%b/%b expected 00010000/0002/0/0", o.dvd, o.dvs, o.is8, o.sgn);
    end
    n_tests++;
    if (o.start_cnt !== 1) begin
      n_fail++; $display("FAIL div16_start_pulse: got %0d cycles expected 1", o.start_cnt);
    end
    n_tests++;
    if (o.lat !== 2 + 3) begin
      n_fail++; $display("FAIL div16_latency: got %0d expected 5", o.lat);
    end
    n_tests++;
    if (!o.stable || !o.ready_after) begin
      n_fail++; $display("FAIL div16_stable_ready: got stable=%0d ready=%0d expected 1/1", o.stable, o.ready_after);
    end
  endtask

  task automatic test_idiv8();
    obs_t o;
    wb_t e;
    run_txn(2'd1, 1'b1, 16'hFFF9, 16'h1234, 16'h5502, 2, 1, 0, 0, o);
    e = exp_q.pop_front();
    n_tests++;
    if (!o.got || key(o.res) !== key(e) || o.res.ax !== 16'hFFFD) begin
      n_fail++; $display("FAIL idiv8_result: got %h expected %h (ax FFFD)", key(o.res), key(e));
    end
    n_tests++;
    if ({o.dvd, o.dvs, o.is8, o.sgn} !== {32'h0000_FFF9, 16'h0002, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL idiv8_operands: got %h/%h/%b/%b expected 0000fff9/0002/1/1", o.dvd, o.dvs, o.is8, o.sgn);
    end
  endtask

  task automatic test_aam();
    obs_t o;
    wb_t e;
    run_txn(2'd2, 1'b0, 16'h123F, 16'h5555, 16'h770A, 4, 1, 0, 0, o);
    e = exp_q.pop_front();
    n_tests++;
    if (!o.got || key(o.res) !== key(e) || o.res.ax !== 16'h0603) begin
      n_fail++; $display("FAIL aam_result: got %h expected %h (ax 0603)", key(o.res), key(e));
    end
    n_tests++;
    if ({o.dvd, o.dvs, o.is8, o.sgn} !== {32'h0000_003F, 16'h000A, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL aam_operands: got %h/%h/%b/%b expected 0000003f/000a/1/0", o.dvd, o.dvs, o.is8, o.sgn);
    end
    // Zero immediate: the divider reports an error, no writeback may appear.
    run_txn(2'd2, 1'b1, 16'h003F, 16'h0000, 16'h0000, 2, 1, 0, 0, o);
    e = exp_q.pop_front();
    n_tests++;
    if (!o.got || key(o.res) !== key(e)) begin
      n_fail++; $display("FAIL aam_zero_fault: got %h expected %h", key(o.res), key(e));
    end
  endtask

  task automatic test_overflow_hold();
    obs_t o;
    wb_t e;
    run_txn(2'd0, 1'b1, 16'h0400, 16'h0000, 16'h0002, 5, 1, 0, 5, o);
    e = exp_q.pop_front();
    n_tests++;
    if (!o.got || key(o.res) !== key(e)) begin
      n_fail++; $display("FAIL div8_overflow: got %h expected %h", key(o.res), key(e));
    end
    n_tests++;
    if (!o.held || !o.ready_after) begin
      n_fail++; $display("FAIL fault_hold: got held=%0d ready=%0d expected 1/1", o.held, o.ready_after);
    end
  endtask

  task automatic test_reserved();
    obs_t o;
    wb_t e;
    run_txn(2'd3, 1'b0, 16'h1111, 16'h2222, 16'h0003, 1, 1, 0, 0, o);
    e = exp_q.pop_front();
    n_tests++;
    if (!o.got || key(o.res) !== key(e) || o.start_cnt !== 0 || o.lat !== 1) begin
      n_fail++; $display("FAIL reserved_op: got %h starts=%0d lat=%0d expected %h starts=0 lat=1",
                         key(o.res), o.start_cnt, o.lat, key(e));
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    wb_t e;
    run_txn(2'd0, 1'b0, 16'h1000, 16'h0000, 16'h0010, 1, 0, 1, 0, o);
    e = exp_q.pop_front();
    n_tests++;
    if (!o.got || key(o.res) !== key(e)) begin
      n_fail++; $display("FAIL timeout_fault: got %h expected %h", key(o.res), key(e));
    end
    // Cycles following the div_start cycle until fault_timeout is seen.
    n_tests++;
    if (o.lat - o.start_at - 1 !== int'(TIMEOUT)) begin
      n_fail++; $display("FAIL timeout_gap: got %0d expected %0d", o.lat - o.start_at - 1, TIMEOUT);
    end
  endtask

  task automatic test_complete_wins();
    obs_t o;
    wb_t e;
    run_txn(2'd0, 1'b0, 16'h0064, 16'h0000, 16'h0007, int'(TIMEOUT), 1, 0, 0, o);
    e = exp_q.pop_front();
    n_tests++;
    if (!o.got || key(o.res) !== key(e)) begin
      n_fail++; $display("FAIL complete_vs_timeout: got %h expected %h", key(o.res), key(e));
    end
  endtask

  task automatic test_ignore_complete();
    obs_t o;
    wb_t e;
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      div_complete = 1'b1; div_error = 1'b1;
      if (req_ready !== 1'b1 || wb_valid !== 1'b0 || fault !== 1'b0) bad++;
    end
    @(negedge clk);
    div_complete = 1'b0; div_error = 1'b0;
    n_tests++;
    if (bad !== 0 || req_ready !== 1'b1 || fault !== 1'b0) begin
      n_fail++; $display("FAIL idle_complete: got %0d bad cycles ready=%b fault=%b expected 0/1/0", bad, req_ready, fault);
    end
    // A completion during the ISSUE cycle is dropped, so the wait times out.
    run_txn(2'd0, 1'b0, 16'h0064, 16'h0000, 16'h000A, 0, 1, 1, 0, o);
    e = exp_q.pop_front();
    n_tests++;
    if (!o.got || key(o.res) !== key(e)) begin
      n_fail++; $display("FAIL issue_complete: got %h expected %h", key(o.res), key(e));
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    wb_t e;
    int cyc;
    int bad;
    bit seen;
    cyc = 0; bad = 0; seen = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && cyc < LIMIT) begin @(negedge clk); cyc++; end
    req_op = 2'd0; req_is_8_bit = 1'b0; req_ax = 16'h0064; req_dx = 16'h0; req_src = 16'h000A;
    req_valid = 1'b1;
    cyc = 0;
    while (!seen && cyc < LIMIT) begin
      @(negedge clk); cyc++;
      req_valid = 1'b0;
      if (div_start === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL rst_wait_start: got no div_start expected one"); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({req_ready, div_start, wb_valid, fault, fault_timeout, wb_ax, wb_dx_en} !== 22'h0) begin
      n_fail++; $display("FAIL rst_mid_wait: got %h expected 0",
                         {req_ready, div_start, wb_valid, fault, fault_timeout, wb_ax, wb_dx_en});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      if (wb_valid !== 1'b0 || fault !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_discard: got %0d bad cycles ready=%b expected 0/1", bad, req_ready);
    end
    run_txn(2'd0, 1'b0, 16'h0064, 16'h0000, 16'h000A, 2, 1, 0, 0, o);
    e = exp_q.pop_front();
    n_tests++;
    if (!o.got || key(o.res) !== key(e) || {o.res.ax, o.res.dx} !== {16'h000A, 16'h0000}) begin
      n_fail++; $display("FAIL after_reset_div16: got %h expected %h", key(o.res), key(e));
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    wb_t e;
    logic [1:0] op;
    logic is8;
    for (int i = 0; i < 10; i++) begin
      op  = 2'($urandom_range(0, 2));
      is8 = 1'($urandom_range(0, 1));
      run_txn(op, is8, 16'($urandom), 16'($urandom_range(0, 3)), 16'($urandom_range(3, 65535)),
              int'($urandom_range(1, 6)), 1, 0, 0, o);
      e = exp_q.pop_front();
      n_tests++;
      if (!o.got || key(o.res) !== key(e) || !o.ready_after) begin
        n_fail++; $display("FAIL b2b_%0d op%0d: got %h ready=%0d expected %h ready=1",
                           i, op, key(o.res), o.ready_after, key(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_div16();
    test_idiv8();
    test_aam();
    test_overflow_hold();
    test_reserved();
    test_timeout();
    test_complete_wins();
    test_ignore_complete();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
